ad9826_sif_arbiter: RTL and testbench
=====================================

# ad9826_sif_arbiter

Round-robin arbiter and sequencer that shares the single AD9826 3-wire serial interface engine between several register-access requesters, for example the power-up configuration sequencer, host register access and a periodic readback monitor. It sits between those requesters and the serial engine. It serializes their write and read transactions, latches the command of the granted requester, and routes completion, read data and errors back to that owner only. A watchdog aborts any transaction the engine never completes.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- TIMEOUT, 4096, watchdog limit in clk cycles for one transaction (≥ 16)

Ports:
- clk  in  1  system clock, also the serial engine clock
- rst_n  in  1  asynchronous, active-low reset
- req_wr_in  in  NREQ  per-requester write request, level, held until that requester's done or err pulse
- req_rd_in  in  NREQ  per-requester read request, level, same hold rule
- req_addr_in  in  3*NREQ  register address; requester i occupies bits [3i+2:3i]
- req_data_in  in  9*NREQ  write data; requester i occupies bits [9i+8:9i]
- req_done_o  out  NREQ  one-cycle pulse to the owner when its write or read completes
- req_err_o  out  NREQ  one-cycle pulse to the owner when its transaction times out
- req_rd_data_o  out  9  read data, valid only while the owner's req_done_o is high after a read
- owner_o  out  3  index of the current or last granted requester
- busy_o  out  1  high from grant through completion
- si_wr_o  out  1  write command pulse to the serial engine
- si_rd_o  out  1  read command pulse to the serial engine
- si_addr_o  out  3  latched address
- si_wr_data_o  out  9  latched write data
- si_ready_in  in  1  engine idle and able to accept a command
- si_done_in  in  1  engine write-complete pulse
- si_rd_data_in  in  9  engine read data
- si_rd_valid_in  in  1  engine read-data-valid pulse

## Operation
- **Pending vector:** bit i = req_wr_in[i] | req_rd_in[i].
- **IDLE:**
  - If any request is pending, grant the first pending index at or after rr_ptr, searching upward with wrap-around.
  - Latch into registers: owner, addr, data and op. op = write if the owner's req_wr_in is high, else read. When a requester asserts both, the write wins and the read stays pending.
  - Set rr_ptr = owner+1, wrapping from NREQ-1 to 0. Go to ISSUE.
- **ISSUE:**
  - While si_ready_in=0, wait with no timeout counting.
  - When si_ready_in=1, assert si_wr_o or si_rd_o for exactly one cycle, clear the watchdog counter, and go to WAIT.
- **WAIT:**
  - Write: completes on si_done_in.
  - Read: completes on si_rd_valid_in. On that cycle, capture si_rd_data_in into req_rd_data_o.
  - Completion pulses from the engine for the other operation type are ignored.
  - On completion, go to RESP.
  - If the watchdog reaches TIMEOUT-1 first, go to RESP with the error flag set.
- **RESP (one cycle):**
  - Pulse req_done_o[owner], or req_err_o[owner] if the error flag is set. Never both.
  - Return to IDLE.
- **Request withdrawal:** if a requester drops its request after grant, the transaction still runs to completion, and the done pulse is still issued.
- **Out-of-range:** requester indices ≥ NREQ are never granted.

## Timing
- **Reset:**
  - All outputs are 0: req_done_o, req_err_o, req_rd_data_o, owner_o, busy_o, si_wr_o, si_rd_o, si_addr_o, si_wr_data_o.
  - rr_ptr = 0, state = IDLE.
  - Reset asserted mid-transaction aborts it immediately. No done or err pulse is issued, and the engine command pulse is withdrawn.
- **Latency:** request seen in IDLE → command pulse 2 cycles later if si_ready_in=1 (IDLE→ISSUE, then ISSUE issues).
- **Response timing:**
  - The engine completion pulse in cycle t gives req_done_o in cycle t+1.
  - The next grant can occur in cycle t+2.
- **Outputs:**
  - si_addr_o and si_wr_data_o are stable from ISSUE through RESP.
  - All outputs are registered.
- **busy_o:** high in ISSUE, WAIT and RESP.
- **Simultaneous events:** a completion and a timeout in the same cycle count as completion.
- **Watchdog width:** clog2(TIMEOUT) bits, with no wrap before it fires.

## Test plan
- **Single write:** requester 0 writes addr 0, data 0x0C8; engine done after 40 cycles → si_wr_o pulses once with addr 0 and data 0x0C8, then req_done_o[0] pulses once, and busy_o falls.
- **Single read:** requester 1 reads addr 1; engine returns 0x0C0 with si_rd_valid_in → req_rd_data_o = 0x0C0 and req_done_o[1] pulse in the same cycle; req_done_o[0] and req_done_o[2] stay 0.
- **Round robin:** all three requesters hold write requests continuously → grants go 0,1,2,0,1,2; no requester is granted twice in a row.
- **Write/read priority:** requester 2 asserts both wr and rd to addr 5 → the write is served first, then the read on a later grant.
- **Timeout:** engine never completes a read; TIMEOUT=16 → req_err_o pulses exactly 16 cycles after the command, no req_done_o, and the next pending request is then granted.
- **Ready stall and reset:** si_ready_in held low for 100 cycles → no command and no error; rst_n asserted in WAIT → all outputs 0 in the same cycle, and the state returns to IDLE.

Source files
------------

// File: rtl/ad9826_sif_arbiter_if.sv
// Requester-side and serial-engine-side signals of the AD9826 serial-interface arbiter.
// master = arbiter, slave = requesters plus serial engine.
interface ad9826_sif_arbiter_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]   req_wr_in;
  logic [NREQ-1:0]   req_rd_in;
  logic [3*NREQ-1:0] req_addr_in;
  logic [9*NREQ-1:0] req_data_in;
  logic [NREQ-1:0]   req_done_o;
  logic [NREQ-1:0]   req_err_o;
  logic [8:0]        req_rd_data_o;
  logic [2:0]        owner_o;
  logic              busy_o;
  logic              si_wr_o;
  logic              si_rd_o;
  logic [2:0]        si_addr_o;
  logic [8:0]        si_wr_data_o;
  logic              si_ready_in;
  logic              si_done_in;
  logic [8:0]        si_rd_data_in;
  logic              si_rd_valid_in;

  modport master (
    input  req_wr_in, req_rd_in, req_addr_in, req_data_in,
           si_ready_in, si_done_in, si_rd_data_in, si_rd_valid_in,
    output req_done_o, req_err_o, req_rd_data_o, owner_o, busy_o,
           si_wr_o, si_rd_o, si_addr_o, si_wr_data_o
  );

  modport slave (
    output req_wr_in, req_rd_in, req_addr_in, req_data_in,
           si_ready_in, si_done_in, si_rd_data_in, si_rd_valid_in,
    input  req_done_o, req_err_o, req_rd_data_o, owner_o, busy_o,
           si_wr_o, si_rd_o, si_addr_o, si_wr_data_o
  );
endinterface

// File: rtl/ad9826_sif_arbiter.sv
// Round-robin arbiter sharing one AD9826 serial engine between NREQ register requesters,
// with a per-transaction watchdog that turns a stuck engine into an error pulse.
module ad9826_sif_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic                  clk,
  input logic                  rst_n,
  ad9826_sif_arbiter_if.master bus
);
  localparam int unsigned WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_state_nx;
  logic [2:0]      r_ptr, w_ptr_nx;
  logic [2:0]      r_owner, w_owner_nx;
  logic [2:0]      r_addr, w_addr_nx;
  logic [8:0]      r_data, w_data_nx;
  logic            r_is_rd, w_is_rd_nx;
  logic [WDW-1:0]  r_wdog, w_wdog_nx;
  logic [NREQ-1:0] r_done, w_done_nx;
  logic [NREQ-1:0] r_err, w_err_nx;
  logic [8:0]      r_rd_data, w_rd_data_nx;
  logic            r_busy, w_busy_nx;
  logic            r_si_wr, w_si_wr_nx;
  logic            r_si_rd, w_si_rd_nx;

  logic [NREQ-1:0] w_pend;
  logic [NREQ-1:0] w_owner_oh;
  logic            w_found;
  logic [2:0]      w_gnt;
  logic            w_gnt_wr;
  logic [2:0]      w_gnt_addr;
  logic [8:0]      w_gnt_data;
  logic            w_complete;

  assign w_pend     = bus.req_wr_in | bus.req_rd_in;
  assign w_owner_oh = NREQ'(1) << r_owner;
  assign w_complete = r_is_rd ? bus.si_rd_valid_in : bus.si_done_in;

  // Round-robin pick: first pending index at/after r_ptr, else lowest pending overall.
  always_comb begin
    w_found    = 1'b0;
    w_gnt      = '0;
    w_gnt_wr   = 1'b0;
    w_gnt_addr = '0;
    w_gnt_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && w_pend[i] && (3'(i) >= r_ptr)) begin
        w_found    = 1'b1;
        w_gnt      = 3'(i);
        w_gnt_wr   = bus.req_wr_in[i];
        w_gnt_addr = bus.req_addr_in[3*i +: 3];
        w_gnt_data = bus.req_data_in[9*i +: 9];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && w_pend[i]) begin
        w_found    = 1'b1;
        w_gnt      = 3'(i);
        w_gnt_wr   = bus.req_wr_in[i];
        w_gnt_addr = bus.req_addr_in[3*i +: 3];
        w_gnt_data = bus.req_data_in[9*i +: 9];
      end
    end
  end

  // Next-state and next-output logic; pulses default low so they last one cycle.
  always_comb begin
    w_state_nx   = r_state;
    w_ptr_nx     = r_ptr;
    w_owner_nx   = r_owner;
    w_addr_nx    = r_addr;
    w_data_nx    = r_data;
    w_is_rd_nx   = r_is_rd;
    w_wdog_nx    = r_wdog;
    w_done_nx    = '0;
    w_err_nx     = '0;
    w_rd_data_nx = r_rd_data;
    w_si_wr_nx   = 1'b0;
    w_si_rd_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nx = w_gnt;
          w_addr_nx  = w_gnt_addr;
          w_data_nx  = w_gnt_data;
          w_is_rd_nx = !w_gnt_wr;
          w_ptr_nx   = (w_gnt == 3'(NREQ-1)) ? 3'd0 : w_gnt + 3'd1;
          w_state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.si_ready_in) begin
          w_si_wr_nx = !r_is_rd;
          w_si_rd_nx = r_is_rd;
          w_wdog_nx  = '0;
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // Completion outranks a watchdog expiry in the same cycle.
        if (w_complete) begin
          w_done_nx  = w_owner_oh;
          if (r_is_rd) w_rd_data_nx = bus.si_rd_data_in;
          w_state_nx = S_RESP;
        end else if (r_wdog == WDW'(TIMEOUT-1)) begin
          w_err_nx   = w_owner_oh;
          w_state_nx = S_RESP;
        end else begin
          w_wdog_nx  = r_wdog + 1'b1;
        end
      end
      S_RESP:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_is_rd   <= 1'b0;
      r_wdog    <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_rd_data <= '0;
      r_busy    <= 1'b0;
      r_si_wr   <= 1'b0;
      r_si_rd   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_ptr     <= w_ptr_nx;
      r_owner   <= w_owner_nx;
      r_addr    <= w_addr_nx;
      r_data    <= w_data_nx;
      r_is_rd   <= w_is_rd_nx;
      r_wdog    <= w_wdog_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
      r_rd_data <= w_rd_data_nx;
      r_busy    <= w_busy_nx;
      r_si_wr   <= w_si_wr_nx;
      r_si_rd   <= w_si_rd_nx;
    end
  end

  assign bus.req_done_o    = r_done;
  assign bus.req_err_o     = r_err;
  assign bus.req_rd_data_o = r_rd_data;
  assign bus.owner_o       = r_owner;
  assign bus.busy_o        = r_busy;
  assign bus.si_wr_o       = r_si_wr;
  assign bus.si_rd_o       = r_si_rd;
  assign bus.si_addr_o     = r_addr;
  assign bus.si_wr_data_o  = r_data;
endmodule

// File: tb/tb_ad9826_sif_arbiter.sv
// Bench for ad9826_sif_arbiter: two instances (default watchdog and TIMEOUT=16) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_ad9826_sif_arbiter;
  localparam int NR   = 3;
  localparam int TO_A = 4096;
  localparam int TO_B = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Stimulus per instance k
  logic [2:0]  wr[2], rd[2];
  logic [8:0]  addr_v[2];
  logic [26:0] data_v[2];
  logic        rdy[2], sdone[2], rdv[2];
  logic [8:0]  rdat[2];

  // Observed outputs per instance k
  logic [2:0] o_done[2], o_err[2], o_own[2], o_addr[2];
  logic [8:0] o_rdd[2], o_wdat[2];
  logic       o_busy[2], o_wr[2], o_rd[2];

  // Model expectations per instance k
  logic [2:0] e_done[2], e_err[2], e_own[2], e_addr[2];
  logic [8:0] e_rdd[2], e_wdat[2];
  logic       e_busy[2], e_wr[2], e_rd[2];
  bit         m_act[2], m_sent[2], m_rep[2], m_isrd[2];
  int         m_ptr[2], m_cmd_cyc[2];
  int         cyc;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  ad9826_sif_arbiter_if #(.NREQ(NR)) ifa ();
  ad9826_sif_arbiter_if #(.NREQ(NR)) ifb ();

  ad9826_sif_arbiter #(.NREQ(NR), .TIMEOUT(TO_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  ad9826_sif_arbiter #(.NREQ(NR), .TIMEOUT(TO_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifa.req_wr_in = wr[0];      assign ifb.req_wr_in = wr[1];
  assign ifa.req_rd_in = rd[0];      assign ifb.req_rd_in = rd[1];
  assign ifa.req_addr_in = addr_v[0]; assign ifb.req_addr_in = addr_v[1];
  assign ifa.req_data_in = data_v[0]; assign ifb.req_data_in = data_v[1];
  assign ifa.si_ready_in = rdy[0];   assign ifb.si_ready_in = rdy[1];
  assign ifa.si_done_in = sdone[0];  assign ifb.si_done_in = sdone[1];
  assign ifa.si_rd_valid_in = rdv[0]; assign ifb.si_rd_valid_in = rdv[1];
  assign ifa.si_rd_data_in = rdat[0]; assign ifb.si_rd_data_in = rdat[1];

  assign o_done[0] = ifa.req_done_o;    assign o_done[1] = ifb.req_done_o;
  assign o_err[0]  = ifa.req_err_o;     assign o_err[1]  = ifb.req_err_o;
  assign o_rdd[0]  = ifa.req_rd_data_o; assign o_rdd[1]  = ifb.req_rd_data_o;
  assign o_own[0]  = ifa.owner_o;       assign o_own[1]  = ifb.owner_o;
  assign o_busy[0] = ifa.busy_o;        assign o_busy[1] = ifb.busy_o;
  assign o_wr[0]   = ifa.si_wr_o;       assign o_wr[1]   = ifb.si_wr_o;
  assign o_rd[0]   = ifa.si_rd_o;       assign o_rd[1]   = ifb.si_rd_o;
  assign o_addr[0] = ifa.si_addr_o;     assign o_addr[1] = ifb.si_addr_o;
  assign o_wdat[0] = ifa.si_wr_data_o;  assign o_wdat[1] = ifb.si_wr_data_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: got no event want event within bound (t=%0t)", name, $time);
  endtask

  function automatic int to_of(input int k);
    return (k == 0) ? TO_A : TO_B;
  endfunction

  function automatic logic [32:0] outs(input int k);
    return {o_done[k], o_err[k], o_rdd[k], o_own[k], o_busy[k], o_wr[k], o_rd[k], o_addr[k], o_wdat[k]};
  endfunction

  task automatic m_reset(input int k);
    m_act[k] = 0; m_sent[k] = 0; m_rep[k] = 0; m_isrd[k] = 0; m_ptr[k] = 0; m_cmd_cyc[k] = 0;
    e_done[k] = '0; e_err[k] = '0; e_own[k] = '0; e_addr[k] = '0;
    e_rdd[k] = '0; e_wdat[k] = '0; e_busy[k] = 1'b0; e_wr[k] = 1'b0; e_rd[k] = 1'b0;
  endtask

  // One clock of transaction-level behaviour: arbitrate, issue when ready, finish or expire, report.
  task automatic m_step(input int k);
    e_done[k] = '0; e_err[k] = '0; e_wr[k] = 1'b0; e_rd[k] = 1'b0;
    if (m_rep[k]) begin
      m_rep[k]  = 0;
      e_busy[k] = 1'b0;
    end else if (!m_act[k]) begin
      for (int off = 0; off < NR; off++) begin
        int j;
        j = (m_ptr[k] + off) % NR;
        if (!m_act[k] && (wr[k][j] || rd[k][j])) begin
          m_act[k]  = 1;
          m_sent[k] = 0;
          m_isrd[k] = !wr[k][j];
          e_own[k]  = 3'(j);
          e_addr[k] = addr_v[k][3*j +: 3];
          e_wdat[k] = data_v[k][9*j +: 9];
          m_ptr[k]  = (j + 1) % NR;
          e_busy[k] = 1'b1;
        end
      end
    end else if (!m_sent[k]) begin
      if (rdy[k]) begin
        m_sent[k]    = 1;
        m_cmd_cyc[k] = cyc;
        if (m_isrd[k]) e_rd[k] = 1'b1; else e_wr[k] = 1'b1;
      end
    end else if (m_isrd[k] ? rdv[k] : sdone[k]) begin
      e_done[k] = 3'b001 << e_own[k];
      if (m_isrd[k]) e_rdd[k] = rdat[k];
      m_act[k] = 0;
      m_rep[k] = 1;
    end else if (cyc - m_cmd_cyc[k] == to_of(k)) begin
      e_err[k] = 3'b001 << e_own[k];
      m_act[k] = 0;
      m_rep[k] = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) m_reset(k);
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) m_step(k);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_a", outs(0), {e_done[0], e_err[0], e_rdd[0], e_own[0], e_busy[0], e_wr[0], e_rd[0], e_addr[0], e_wdat[0]});
      check("cyc_b", outs(1), {e_done[1], e_err[1], e_rdd[1], e_own[1], e_busy[1], e_wr[1], e_rd[1], e_addr[1], e_wdat[1]});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cmd(input int k, output bit got);
    got = 0;
    for (int n = 0; n < 300; n++) begin
      if (o_wr[k] || o_rd[k]) begin
        got = 1;
        break;
      end
      tick(1);
    end
    if (!got) bound_fail("cmd_wait");
  endtask

  // Act as the engine for one transaction: complete it 'delay' cycles after the command.
  task automatic serve(input int k, input int delay, input logic [8:0] rdata, input bit drop,
                       output int own, output bit was_rd);
    bit got;
    own = -1;
    was_rd = 0;
    wait_cmd(k, got);
    if (got) begin
      own    = int'(o_own[k]);
      was_rd = o_rd[k];
      tick(delay);
      if (was_rd) begin rdv[k] = 1'b1; rdat[k] = rdata; end
      else sdone[k] = 1'b1;
      tick(1);
      rdv[k] = 1'b0;
      sdone[k] = 1'b0;
      check("done_onehot", o_done[k], 64'(3'b001 << own));
      check("no_err", o_err[k], 0);
      if (was_rd) check("rd_data", o_rdd[k], rdata);
      if (drop) begin
        if (was_rd) rd[k][own] = 1'b0; else wr[k][own] = 1'b0;
      end
      tick(1);
      check("busy_fall", o_busy[k], 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench stuck");
  end

  initial begin
    int  own;
    bit  was_rd, got;
    logic stray;
    int  exp_rr[6];
    exp_rr = '{0, 1, 2, 0, 1, 2};
    for (int k = 0; k < 2; k++) begin
      wr[k] = '0; rd[k] = '0; addr_v[k] = '0; data_v[k] = '0;
      rdy[k] = 1'b1; sdone[k] = 1'b0; rdv[k] = 1'b0; rdat[k] = '0;
      m_reset(k);
    end
    cyc = 0;
    rst_n = 1'b0;
    #12;
    check("reset_a", outs(0), 0);
    check("reset_b", outs(1), 0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // Single write: requester 0, addr 0, data 0x0C8, engine done 40 cycles after command
    addr_v[0][2:0] = 3'd0;
    data_v[0][8:0] = 9'h0C8;
    wr[0][0] = 1'b1;
    tick(1);
    check("lat_no_cmd_yet", o_wr[0], 0);
    check("busy_in_issue", o_busy[0], 1);
    tick(1);
    check("lat_cmd", o_wr[0], 1);
    check("wr_addr", o_addr[0], 0);
    check("wr_data", o_wdat[0], 9'h0C8);
    serve(0, 40, 9'h000, 1'b1, own, was_rd);
    check("wr_owner", own, 0);
    check("wr_op", was_rd, 0);

    // Single read: requester 1, addr 1, engine returns 0x0C0
    addr_v[0][5:3] = 3'd1;
    rd[0][1] = 1'b1;
    wait_cmd(0, got);
    check("rd_addr", o_addr[0], 1);
    serve(0, 10, 9'h0C0, 1'b1, own, was_rd);
    check("rd_owner", own, 1);
    check("rd_op", was_rd, 1);

    // Ready stall for 100 cycles, then reset asserted while waiting on the engine
    rdy[0] = 1'b0;
    addr_v[0][8:6] = 3'd7;
    data_v[0][26:18] = 9'h1FF;
    wr[0][2] = 1'b1;
    stray = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick(1);
      stray = stray | o_wr[0] | o_rd[0] | (|o_err[0]) | (|o_done[0]);
    end
    check("stall_quiet", stray, 0);
    check("stall_busy", o_busy[0], 1);
    rdy[0] = 1'b1;
    wait_cmd(0, got);
    check("stall_addr", o_addr[0], 7);
    check("stall_data", o_wdat[0], 9'h1FF);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", outs(0), 0);
    wr[0][2] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("post_reset_idle", o_busy[0], 0);

    // Round robin with all three writes held continuously
    data_v[0] = {9'h033, 9'h022, 9'h011};
    wr[0] = 3'b111;
    for (int n = 0; n < 6; n++) begin
      serve(0, 3 + n, 9'h000, 1'b0, own, was_rd);
      check("rr_owner", own, exp_rr[n]);
    end
    wr[0] = 3'b000;
    tick(3);
    check("rr_drained", o_busy[0], 0);

    // Requester 2 asks for write and read together: write first, read on a later grant
    addr_v[0][8:6] = 3'd5;
    data_v[0][26:18] = 9'h155;
    wr[0][2] = 1'b1;
    rd[0][2] = 1'b1;
    wait_cmd(0, got);
    check("prio_wr_first", o_wr[0], 1);
    check("prio_addr", o_addr[0], 5);
    serve(0, 4, 9'h000, 1'b1, own, was_rd);
    check("prio_owner1", own, 2);
    check("prio_op1", was_rd, 0);
    serve(0, 6, 9'h1A3, 1'b1, own, was_rd);
    check("prio_owner2", own, 2);
    check("prio_op2", was_rd, 1);

    // Watchdog on the TIMEOUT=16 instance: read never completes, write pending behind it
    addr_v[1][2:0] = 3'd3;
    addr_v[1][5:3] = 3'd4;
    data_v[1][17:9] = 9'h0A5;
    rd[1][0] = 1'b1;
    wr[1][1] = 1'b1;
    wait_cmd(1, got);
    check("to_owner", o_own[1], 0);
    check("to_is_read", o_rd[1], 1);
    tick(15);
    check("to_not_early", o_err[1], 0);
    tick(1);
    check("to_err_pulse", o_err[1], 3'b001);
    check("to_no_done", o_done[1], 0);
    rd[1][0] = 1'b0;
    serve(1, 5, 9'h000, 1'b1, own, was_rd);
    check("to_next_owner", own, 1);
    check("to_next_op", was_rd, 0);
    tick(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
